// File: rtl/spam_arbiter.sv
// Round-robin arbiter sharing one SPAM bus among SPAM_MASTERS requesters.
// Ports: clk/rst; packed req_* in, req_acks/rsp_* out; spamo_* command out, spami_* slave status in.
module spam_arbiter #(
    parameter int SPAM_MASTERS = 2,
    parameter int ADDR_W       = 24,
    parameter int DATA_W       = 32,
    parameter int DID_W        = 4,
    parameter int DID_BASE     = 0,
    parameter int TIMEOUT      = 255
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [SPAM_MASTERS-1:0]        req_valids,
    input  logic [SPAM_MASTERS-1:0]        req_r_nws,
    input  logic [SPAM_MASTERS*ADDR_W-1:0] req_addrs,
    input  logic [SPAM_MASTERS*DATA_W-1:0] req_datas,
    output logic [SPAM_MASTERS-1:0]        req_acks,
    output logic [SPAM_MASTERS-1:0]        rsp_dones,
    output logic [DATA_W-1:0]              rsp_data,
    output logic                           rsp_err,
    output logic                           spamo_valid,
    output logic                           spamo_r_nw,
    output logic [DID_W-1:0]               spamo_did,
    output logic [ADDR_W-1:0]              spamo_addr,
    output logic [DATA_W-1:0]              spamo_data,
    input  logic                           spami_busy_b,
    input  logic [DATA_W-1:0]              spami_data
);

    localparam int GW = (SPAM_MASTERS > 1) ? $clog2(SPAM_MASTERS) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    localparam logic [SPAM_MASTERS-1:0] ONE = SPAM_MASTERS'(1);
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    logic [1:0]        state;
    // Holds the owner of the outstanding command as well as the
    // round-robin pointer; both are the same index.
    logic [GW-1:0]     last_grant;
    logic [15:0]       cnt;

    logic              hi_found;
    logic [GW-1:0]     hi_idx;
    logic              lo_found;
    logic [GW-1:0]     lo_idx;
    logic [GW-1:0]     next_grant;
    logic              sel_r_nw;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    // Rotating priority: the lowest requester above last_grant wins,
    // otherwise wrap around to the lowest requester overall.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_found = 1'b0;
        lo_idx   = '0;
        for (int i = 0; i < SPAM_MASTERS; i++) begin
            if (!hi_found && req_valids[i] && GW'(i) > last_grant) begin
                hi_found = 1'b1;
                hi_idx   = GW'(i);
            end
            if (!lo_found && req_valids[i]) begin
                lo_found = 1'b1;
                lo_idx   = GW'(i);
            end
        end
        next_grant = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        sel_r_nw = 1'b0;
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < SPAM_MASTERS; i++) begin
            if (GW'(i) == next_grant) begin
                sel_r_nw = req_r_nws[i];
                sel_addr = req_addrs[i*ADDR_W +: ADDR_W];
                sel_data = req_datas[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= GW'(SPAM_MASTERS - 1);
            cnt         <= '0;
            req_acks    <= '0;
            rsp_dones   <= '0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
            spamo_valid <= 1'b0;
            spamo_r_nw  <= 1'b0;
            spamo_did   <= '0;
            spamo_addr  <= '0;
            spamo_data  <= '0;
        end else begin
            req_acks    <= '0;
            rsp_dones   <= '0;
            spamo_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req_valids) begin
                        last_grant  <= next_grant;
                        spamo_r_nw  <= sel_r_nw;
                        spamo_addr  <= sel_addr;
                        spamo_data  <= sel_data;
                        spamo_did   <= DID_W'(DID_BASE + int'(next_grant));
                        // Strobe and ack become visible together in ISSUE.
                        spamo_valid <= 1'b1;
                        req_acks    <= ONE << next_grant;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (spami_busy_b) begin
                        rsp_data  <= spamo_r_nw ? spami_data : '0;
                        rsp_err   <= 1'b0;
                        rsp_dones <= ONE << last_grant;
                        state     <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        rsp_data  <= '1;
                        rsp_err   <= 1'b1;
                        rsp_dones <= ONE << last_grant;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spam_arbiter.sv
// Directed bench for spam_arbiter with command/response scoreboards.
// Ports: drives requesters and a slave model; checks every bus strobe and completion.
module tb_spam_arbiter;

    localparam int M    = 2;
    localparam int AW   = 24;
    localparam int DW   = 32;
    localparam int DIDW = 4;
    localparam int TO   = 8;

    typedef struct {
        int          idx;
        logic        rnw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        int          bd;
    } cmd_t;

    typedef struct {
        int          idx;
        logic [DW-1:0] data;
        logic        err;
        int          lat;
    } rsp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [M-1:0]    req_valids;
    logic [M-1:0]    req_r_nws;
    logic [M*AW-1:0] req_addrs;
    logic [M*DW-1:0] req_datas;
    logic [M-1:0]    req_acks;
    logic [M-1:0]    rsp_dones;
    logic [DW-1:0]   rsp_data;
    logic            rsp_err;
    logic            spamo_valid;
    logic            spamo_r_nw;
    logic [DIDW-1:0] spamo_did;
    logic [AW-1:0]   spamo_addr;
    logic [DW-1:0]   spamo_data;
    logic            spami_busy_b;
    logic [DW-1:0]   spami_data;

    always #5 clk = ~clk;

    spam_arbiter #(
        .SPAM_MASTERS(M),
        .ADDR_W(AW),
        .DATA_W(DW),
        .DID_W(DIDW),
        .DID_BASE(0),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valids(req_valids),
        .req_r_nws(req_r_nws),
        .req_addrs(req_addrs),
        .req_datas(req_datas),
        .req_acks(req_acks),
        .rsp_dones(rsp_dones),
        .rsp_data(rsp_data),
        .rsp_err(rsp_err),
        .spamo_valid(spamo_valid),
        .spamo_r_nw(spamo_r_nw),
        .spamo_did(spamo_did),
        .spamo_addr(spamo_addr),
        .spamo_data(spamo_data),
        .spami_busy_b(spami_busy_b),
        .spami_data(spami_data)
    );

    cmd_t        cmd_q[$];
    rsp_t        rsp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          issue_cyc = 0;
    int          issue_at[M];
    int          done_at[M];
    int          wd = 0;
    int          cur_bd = 0;
    logic [DW-1:0] cur_rdata = '0;
    bit          auto_drop = 1'b1;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void expect_txn(input int i, input logic rnw,
                                       input logic [AW-1:0] a,
                                       input logic [DW-1:0] wdat,
                                       input logic [DW-1:0] rdat,
                                       input int bd);
        cmd_t c;
        rsp_t r;
        c.idx = i; c.rnw = rnw; c.addr = a;
        c.wdata = wdat; c.rdata = rdat; c.bd = bd;
        cmd_q.push_back(c);
        r.idx = i;
        if (bd >= TO) begin
            r.data = '1; r.err = 1'b1; r.lat = TO + 1;
        end else begin
            r.data = rnw ? rdat : '0; r.err = 1'b0; r.lat = bd + 2;
        end
        rsp_q.push_back(r);
    endfunction

    task automatic drive(input int i, input logic rnw,
                         input logic [AW-1:0] a, input logic [DW-1:0] wdat);
        req_r_nws[i] = rnw;
        req_addrs[i*AW +: AW] = a;
        req_datas[i*DW +: DW] = wdat;
        req_valids[i] = 1'b1;
    endtask

    task automatic issue(input int i, input logic rnw,
                         input logic [AW-1:0] a, input logic [DW-1:0] wdat,
                         input logic [DW-1:0] rdat, input int bd);
        expect_txn(i, rnw, a, wdat, rdat, bd);
        drive(i, rnw, a, wdat);
    endtask

    // One cycle: sample at negedge, score, then update slave and requesters.
    task automatic step();
        cmd_t c;
        rsp_t r;
        @(negedge clk);
        cyc++;
        if (spamo_valid) begin
            if (cmd_q.size() == 0) begin
                chk("cmd_unexpected", 64'(spamo_valid), 64'd0);
            end else begin
                c = cmd_q.pop_front();
                chk("ack", 64'(req_acks), 64'(1 << c.idx));
                chk("r_nw", 64'(spamo_r_nw), 64'(c.rnw));
                chk("did", 64'(spamo_did), 64'(c.idx));
                chk("addr", 64'(spamo_addr), 64'(c.addr));
                chk("wdata", 64'(spamo_data), 64'(c.wdata));
                issue_cyc = cyc;
                issue_at[c.idx] = cyc;
                cur_bd = c.bd;
                cur_rdata = c.rdata;
                wd = c.bd;
            end
        end else if (req_acks != '0) begin
            chk("ack_without_valid", 64'(req_acks), 64'd0);
        end
        if (rsp_dones != '0) begin
            if (rsp_q.size() == 0) begin
                chk("rsp_unexpected", 64'(rsp_dones), 64'd0);
            end else begin
                r = rsp_q.pop_front();
                chk("dones", 64'(rsp_dones), 64'(1 << r.idx));
                chk("rsp_data", 64'(rsp_data), 64'(r.data));
                chk("rsp_err", 64'(rsp_err), 64'(r.err));
                chk("latency", 64'(cyc - issue_cyc), 64'(r.lat));
                done_at[r.idx] = cyc;
            end
        end
        if (spamo_valid) begin
            spami_busy_b = 1'b0;
            spami_data = 32'hBAD0BAD0;
        end else if (wd > 0) begin
            spami_busy_b = 1'b0;
            spami_data = 32'hBAD0BAD0;
            wd--;
        end else begin
            spami_busy_b = 1'b1;
            spami_data = cur_rdata;
        end
        if (auto_drop) req_valids = req_valids & ~req_acks;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((cmd_q.size() != 0 || rsp_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        chk("drain_pending", 64'(cmd_q.size() + rsp_q.size()), 64'd0);
    endtask

    initial begin
        int acks;
        int n;
        int ack_cyc[4];

        rst = 1'b1;
        req_valids = '0;
        req_r_nws = '0;
        req_addrs = '0;
        req_datas = '0;
        spami_busy_b = 1'b1;
        spami_data = '0;

        // Reset state
        step();
        step();
        chk("rst_valid", 64'(spamo_valid), 64'd0);
        chk("rst_acks", 64'(req_acks), 64'd0);
        chk("rst_dones", 64'(rsp_dones), 64'd0);
        chk("rst_rdata", 64'(rsp_data), 64'd0);
        chk("rst_addr", 64'(spamo_addr), 64'd0);
        rst = 1'b0;
        step();

        // 1: single read, slave busy for 3 WAIT cycles
        issue(0, 1'b1, 24'h000010, 32'h0, 32'hDEADBEEF, 3);
        drain(40);

        // 2: write from requester 1, immediate completion
        issue(1, 1'b0, 24'h000004, 32'h12345678, 32'h0, 0);
        drain(40);
        chk("t2_hold_data", 64'(rsp_data), 64'd0);

        // 3: both requesters continuous, strict alternation
        expect_txn(0, 1'b1, 24'h000100, 32'h0, 32'h11111111, 0);
        expect_txn(1, 1'b1, 24'h000200, 32'h0, 32'h22222222, 0);
        expect_txn(0, 1'b1, 24'h000100, 32'h0, 32'h11111111, 0);
        expect_txn(1, 1'b1, 24'h000200, 32'h0, 32'h22222222, 0);
        auto_drop = 1'b0;
        drive(0, 1'b1, 24'h000100, 32'h0);
        drive(1, 1'b1, 24'h000200, 32'h0);
        acks = 0;
        n = 0;
        while (acks < 4 && n < 60) begin
            step();
            n++;
            if (req_acks != '0) begin
                ack_cyc[acks] = cyc;
                acks++;
            end
        end
        req_valids = '0;
        auto_drop = 1'b1;
        chk("t3_ack_count", 64'(acks), 64'd4);
        drain(40);
        chk("t3_gap01", 64'(ack_cyc[1] - ack_cyc[0]), 64'd3);
        chk("t3_gap23", 64'(ack_cyc[3] - ack_cyc[2]), 64'd3);

        // 4: timeout, then a normal transaction
        issue(0, 1'b1, 24'h000020, 32'h0, 32'h00000055, 1000);
        drain(60);
        issue(1, 1'b1, 24'h000030, 32'h0, 32'hCAFEF00D, 1);
        drain(40);

        // 5: reset in the middle of WAIT
        issue(0, 1'b1, 24'h000040, 32'h0, 32'h00000001, 1000);
        n = 0;
        while (cmd_q.size() != 0 && n < 20) begin
            step();
            n++;
        end
        chk("t5_issued", 64'(cmd_q.size()), 64'd0);
        step();
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("t5_async_addr", 64'(spamo_addr), 64'd0);
        chk("t5_async_rdata", 64'(rsp_data), 64'd0);
        chk("t5_async_err", 64'(rsp_err), 64'd0);
        chk("t5_async_dones", 64'(rsp_dones), 64'd0);
        if (rsp_q.size() != 0) void'(rsp_q.pop_front());
        step();
        step();
        rst = 1'b0;
        issue(0, 1'b1, 24'h000044, 32'h0, 32'h0BADF00D, 0);
        issue(1, 1'b0, 24'h000048, 32'h87654321, 32'h0, 0);
        drain(60);

        // 6: requester 1 arrives while requester 0 waits
        issue(0, 1'b1, 24'h000050, 32'h0, 32'hA5A5A5A5, 4);
        n = 0;
        while (cmd_q.size() != 0 && n < 20) begin
            step();
            n++;
        end
        step();
        issue(1, 1'b0, 24'h000060, 32'h00000077, 32'h0, 0);
        drain(60);
        chk("t6_grant_gap", 64'(issue_at[1] - done_at[0]), 64'd1);

        repeat (3) step();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
